// File: rtl/exec_stage_pipe_pkg.sv
// ============================================================================
//  Module   : exec_pkg
//  Purpose  : Shared opcodes, SrcB selects, flag indices and FSM encoding
//             for the pipelined execute stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package exec_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_ORR = 3'b011;
  localparam logic [2:0] OP_EOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  localparam logic [1:0] SRCB_RD2    = 2'd0;
  localparam logic [1:0] SRCB_IMM    = 2'd1;
  localparam logic [1:0] SRCB_IMM_AL = 2'd2;
  localparam logic [1:0] SRCB_ONES   = 2'd3;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/exec_stage_pipe_if.sv
// ============================================================================
//  Module   : exec_stage_pipe_if
//  Purpose  : Operand/handshake bundle between decode, execute and writeback.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface exec_stage_pipe_if #(
  parameter int WIDTH = 32,
  parameter int IMM_W = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] RD1;
  logic [WIDTH-1:0] RD2;
  logic [IMM_W-1:0] Imm;
  logic             ImmSrc;
  logic [1:0]       ALUSrc;
  logic [2:0]       ALUControl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic [3:0]       ALUFlags;
  logic             busy;

  modport slave (
    input  in_valid, RD1, RD2, Imm, ImmSrc, ALUSrc, ALUControl, out_ready,
    output in_ready, out_valid, ALUResult, ALUFlags, busy
  );

  modport master (
    output in_valid, RD1, RD2, Imm, ImmSrc, ALUSrc, ALUControl, out_ready,
    input  in_ready, out_valid, ALUResult, ALUFlags, busy
  );
endinterface

`default_nettype wire

// File: rtl/exec_stage_pipe_iter_mul.sv
// ============================================================================
//  Module   : exec_iter_mul
//  Purpose  : Iterative shift-add multiplier, one partial product per step.
//             EXEC_MUL_EARLY_TERM_EN: finish once the multiplier runs out.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_iter_mul #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_start,
  input  wire logic             i_step,
  input  wire logic [WIDTH-1:0] i_a,
  input  wire logic [WIDTH-1:0] i_b,
  output logic                  o_done,
  output logic      [WIDTH-1:0] o_result
);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH-1:0] w_acc_next;

  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next = r_acc + w_addend;
  // o_result is the accumulator value this step will write, valid with o_done
  assign o_result   = w_acc_next;

`ifdef EXEC_MUL_EARLY_TERM_EN
  assign o_done = i_step && ((r_cnt == CNT_W'(1)) || (r_mplier[WIDTH-1:1] == '0));
`else
  assign o_done = i_step && (r_cnt == CNT_W'(1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (i_start) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= CNT_W'(WIDTH);
    end else if (i_step) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/exec_stage_pipe.sv
// ============================================================================
//  Module   : exec_stage_pipe
//  Purpose  : Registered execute stage with valid/ready handshakes and an
//             iterative MUL. Optional macro EXEC_MUL_EARLY_TERM_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module exec_stage_pipe
  import exec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IMM_W = 24,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input wire logic         clk,
  input wire logic         reset,
  exec_stage_pipe_if.slave bus
);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_flags;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_mul_start;
  logic             w_mul_done;
  logic [WIDTH-1:0] w_mul_res;
  logic [WIDTH-1:0] w_ext_imm;
  logic [WIDTH-1:0] w_srcb;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_c;
  logic             w_alu_v;
  logic [3:0]       w_alu_flags;
  logic [3:0]       w_mul_flags;

  assign w_in_ready = !reset && (r_state == IDLE) && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_is_mul   = (bus.ALUControl == OP_MUL);

  // ImmSrc=0 deliberately ignores Imm above bit 11
  assign w_ext_imm = bus.ImmSrc ? {{(WIDTH-IMM_W){bus.Imm[IMM_W-1]}}, bus.Imm}
                                : {{(WIDTH-12){1'b0}}, bus.Imm[11:0]};

  always_comb begin
    w_srcb = bus.RD2;
    case (bus.ALUSrc)
      SRCB_RD2:    w_srcb = bus.RD2;
      SRCB_IMM:    w_srcb = w_ext_imm;
      SRCB_IMM_AL: w_srcb = w_ext_imm << 2;
      SRCB_ONES:   w_srcb = '1;
      default:     w_srcb = bus.RD2;
    endcase
  end

  assign w_sum  = {1'b0, bus.RD1} + {1'b0, w_srcb};
  assign w_diff = {1'b0, bus.RD1} + {1'b0, ~w_srcb} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    w_alu_res = bus.RD1;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (bus.ALUControl)
      OP_ADD: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = (bus.RD1[WIDTH-1] == w_srcb[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != bus.RD1[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_res = w_diff[WIDTH-1:0];
        w_alu_c   = w_diff[WIDTH];
        w_alu_v   = (bus.RD1[WIDTH-1] != w_srcb[WIDTH-1]) &&
                    (w_diff[WIDTH-1] != bus.RD1[WIDTH-1]);
      end
      OP_AND:  w_alu_res = bus.RD1 & w_srcb;
      OP_ORR:  w_alu_res = bus.RD1 | w_srcb;
      OP_EOR:  w_alu_res = bus.RD1 ^ w_srcb;
      default: w_alu_res = bus.RD1;
    endcase
  end

  always_comb begin
    w_alu_flags         = 4'b0000;
    w_alu_flags[FLAG_N] = w_alu_res[WIDTH-1];
    w_alu_flags[FLAG_Z] = (w_alu_res == '0);
    w_alu_flags[FLAG_C] = w_alu_c;
    w_alu_flags[FLAG_V] = w_alu_v;
    w_mul_flags         = 4'b0000;
    w_mul_flags[FLAG_N] = w_mul_res[WIDTH-1];
    w_mul_flags[FLAG_Z] = (w_mul_res == '0);
  end

  exec_iter_mul #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk      (clk),
    .rst      (reset),
    .i_start  (w_mul_start),
    .i_step   (r_state == BUSY),
    .i_a      (bus.RD1),
    .i_b      (w_srcb),
    .o_done   (w_mul_done),
    .o_result (w_mul_res)
  );

  always_comb begin
    w_state_next = r_state;
    w_mul_start  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && w_is_mul) begin
          w_state_next = BUSY;
          w_mul_start  = 1'b1;
        end
      end
      BUSY: begin
        if (w_mul_done) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // A MUL accept drops out_valid so the register is empty when it completes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= 4'b0000;
    end else if ((r_state == BUSY) && w_mul_done) begin
      r_out_valid <= 1'b1;
      r_result    <= w_mul_res;
      r_flags     <= w_mul_flags;
    end else if (w_accept && !w_is_mul) begin
      r_out_valid <= 1'b1;
      r_result    <= w_alu_res;
      r_flags     <= w_alu_flags;
    end else if (w_accept || bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.ALUResult = r_result;
  assign bus.ALUFlags  = r_flags;
  assign bus.busy      = (r_state == BUSY);

endmodule

`default_nettype wire

// File: tb/tb_exec_stage_pipe.sv
// ============================================================================
//  Module   : tb_exec_stage_pipe
//  Purpose  : Directed self-checking bench for exec_stage_pipe.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_exec_stage_pipe;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  exec_stage_pipe_if #(.WIDTH(32), .IMM_W(24)) bus ();

  exec_stage_pipe #(.WIDTH(32), .IMM_W(24)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  src;
    logic        imms;
    logic [31:0] a;
    logic [31:0] b;
    logic [23:0] imm;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  task automatic drive(input logic [2:0] op, input logic [1:0] src, input logic imms,
                       input logic [31:0] a, input logic [31:0] b, input logic [23:0] imm);
    bus.ALUControl = op;
    bus.ALUSrc     = src;
    bus.ImmSrc     = imms;
    bus.RD1        = a;
    bus.RD2        = b;
    bus.Imm        = imm;
    bus.in_valid   = 1'b1;
  endtask

  // Waits (bounded) for the accept edge, then withdraws in_valid
  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.in_ready === 1'b1) begin
        @(posedge clk); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: out_valid=%b busy=%b in_ready=%b, expected 0 0 0",
               bus.out_valid, bus.busy, bus.in_ready);
    end
    n_checks++;
    if (bus.ALUResult !== 32'h0 || bus.ALUFlags !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_data: result=%h flags=%b, expected 0 0000", bus.ALUResult, bus.ALUFlags);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b, expected 1", bus.in_ready);
    end
  endtask

  task automatic test_alu_ops;
    vec_t v[12];
    bit   ok;
    v[0]  = '{3'b000, 2'd0, 1'b0, 32'h7FFFFFFF, 32'h1,       24'h0,      32'h80000000, 4'b1001};
    v[1]  = '{3'b001, 2'd1, 1'b0, 32'h5,        32'h0,       24'h000005, 32'h0,        4'b0110};
    v[2]  = '{3'b000, 2'd2, 1'b1, 32'h8,        32'h0,       24'hFFFFFF, 32'h4,        4'b0010};
    v[3]  = '{3'b001, 2'd0, 1'b0, 32'h0,        32'h1,       24'h0,      32'hFFFFFFFF, 4'b1000};
    v[4]  = '{3'b001, 2'd0, 1'b0, 32'h80000000, 32'h1,       24'h0,      32'h7FFFFFFF, 4'b0011};
    v[5]  = '{3'b011, 2'd3, 1'b0, 32'h12,       32'h0,       24'h0,      32'hFFFFFFFF, 4'b1000};
    v[6]  = '{3'b100, 2'd1, 1'b0, 32'h123,      32'h0,       24'hABC123, 32'h0,        4'b0100};
    v[7]  = '{3'b010, 2'd0, 1'b0, 32'h0000F0F0, 32'h00000F0F, 24'h0,     32'h0,        4'b0100};
    v[8]  = '{3'b110, 2'd0, 1'b0, 32'h80000001, 32'h5,       24'h0,      32'h80000001, 4'b1000};
    v[9]  = '{3'b111, 2'd3, 1'b0, 32'h0,        32'h5,       24'h0,      32'h0,        4'b0100};
    v[10] = '{3'b000, 2'd0, 1'b0, 32'hFFFFFFFF, 32'h1,       24'h0,      32'h0,        4'b0110};
    v[11] = '{3'b000, 2'd1, 1'b1, 32'h100,      32'h0,       24'h000800, 32'h900,      4'b0000};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(v[i].op, v[i].src, v[i].imms, v[i].a, v[i].b, v[i].imm);
      wait_accept(ok);
      n_checks++;
      if (!ok || bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL alu_valid[%0d]: accepted=%b out_valid=%b, expected 1 1", i, ok, bus.out_valid);
      end
      n_checks++;
      if (bus.ALUResult !== v[i].res || bus.ALUFlags !== v[i].fl) begin
        n_fail++;
        $display("FAIL alu_result[%0d]: result=%h flags=%b, expected %h %b",
                 i, bus.ALUResult, bus.ALUFlags, v[i].res, v[i].fl);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_drain: out_valid=%b, expected 0", bus.out_valid);
    end
  endtask

  task automatic test_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_res,
                          input logic [3:0] exp_fl, input int exp_lat);
    bit ok;
    bit bad;
    int lat;
    bus.out_ready = 1'b1;
    drive(3'b101, 2'd0, 1'b0, a, b, 24'h0);
    wait_accept(ok);
    lat = 1;
    bad = 1'b0;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (!ok || lat != exp_lat) begin
      n_fail++;
      $display("FAIL mul_latency %h*%h: accepted=%b latency=%0d, expected 1 %0d", a, b, ok, lat, exp_lat);
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL mul_busy %h*%h: busy/in_ready wrong during iteration, expected busy=1 in_ready=0", a, b);
    end
    n_checks++;
    if (bus.ALUResult !== exp_res || bus.ALUFlags !== exp_fl || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_result %h*%h: result=%h flags=%b busy=%b, expected %h %b 0",
               a, b, bus.ALUResult, bus.ALUFlags, bus.busy, exp_res, exp_fl);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    bit ok;
    bit bad;
    bus.out_ready = 1'b0;
    drive(3'b010, 2'd0, 1'b0, 32'h0000F0F0, 32'h0000FF00, 24'h0);
    wait_accept(ok);
    n_checks++;
    if (!ok || bus.out_valid !== 1'b1 || bus.ALUResult !== 32'h0000F000) begin
      n_fail++;
      $display("FAIL bp_first: accepted=%b out_valid=%b result=%h, expected 1 1 0000f000",
               ok, bus.out_valid, bus.ALUResult);
    end
    drive(3'b100, 2'd0, 1'b0, 32'h000000FF, 32'h0000000F, 24'h0);
    bad = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.ALUResult !== 32'h0000F000 ||
          bus.ALUFlags !== 4'b0000) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL bp_hold: result=%h in_ready=%b, expected 0000f000 held with in_ready=0",
               bus.ALUResult, bus.in_ready);
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready: in_ready=%b, expected 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.ALUResult !== 32'h000000F0 || bus.ALUFlags !== 4'b0000) begin
      n_fail++;
      $display("FAIL bp_replace: out_valid=%b result=%h flags=%b, expected 1 000000f0 0000",
               bus.out_valid, bus.ALUResult, bus.ALUFlags);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: out_valid=%b, expected 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_mul;
    bit ok;
    bus.out_ready = 1'b1;
    drive(3'b101, 2'd0, 1'b0, 32'h3, 32'h80000001, 24'h0);
    wait_accept(ok);
    repeat (9) @(posedge clk);
    #1;
    n_checks++;
    if (!ok || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mul_busy: accepted=%b busy=%b, expected 1 1", ok, bus.busy);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0 ||
        bus.ALUResult !== 32'h0 || bus.ALUFlags !== 4'h0) begin
      n_fail++;
      $display("FAIL rst_mul_abort: out_valid=%b busy=%b in_ready=%b result=%h flags=%b, expected 0 0 0 0 0",
               bus.out_valid, bus.busy, bus.in_ready, bus.ALUResult, bus.ALUFlags);
    end
    reset = 1'b0;
    drive(3'b000, 2'd0, 1'b0, 32'h2, 32'h3, 24'h0);
    wait_accept(ok);
    n_checks++;
    if (!ok || bus.out_valid !== 1'b1 || bus.ALUResult !== 32'h5 || bus.ALUFlags !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_first_op: accepted=%b out_valid=%b result=%h flags=%b, expected 1 1 00000005 0000",
               ok, bus.out_valid, bus.ALUResult, bus.ALUFlags);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.RD1       = '0;
    bus.RD2       = '0;
    bus.Imm       = '0;
    bus.ImmSrc    = 1'b0;
    bus.ALUSrc    = 2'd0;
    bus.ALUControl = 3'd0;
    bus.out_ready = 1'b1;
    test_reset;
    test_alu_ops;
`ifdef EXEC_MUL_EARLY_TERM_EN
    test_mul(32'h6,        32'h7,        32'd42, 4'b0000, 4);
    test_mul(32'h00010000, 32'h00010000, 32'h0,  4'b0100, 18);
    test_mul(32'h5,        32'h0,        32'h0,  4'b0100, 2);
`else
    test_mul(32'h6,        32'h7,        32'd42, 4'b0000, 33);
    test_mul(32'h00010000, 32'h00010000, 32'h0,  4'b0100, 33);
    test_mul(32'h5,        32'h0,        32'h0,  4'b0100, 33);
`endif
    test_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 4'b0000, 33);
    test_mul(32'h3,        32'h80000001, 32'h80000003, 4'b1000, 33);
    test_backpressure;
    test_reset_mid_mul;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/exec_stage_pipe.md
Name: exec_stage_pipe

Overview:
- Parametrised, registered successor of the single-cycle execute stage.
- Per operation: extends the immediate, selects SrcB, computes the ALU result and NZCV flags, and returns them on a valid/ready output register.
- Adds an iterative shift-add MUL with multi-cycle latency, plus input/output handshakes for use between the decode and writeback pipeline registers.

Parameters:
- WIDTH, 32: datapath width of RD1, RD2, result and ExtImm.
- IMM_W, 24: immediate field width. Must be 12 or more and less than WIDTH.
- CNT_W, $clog2(WIDTH+1): width of the MUL iteration counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operation offered
- in_ready  out  1  stage accepts this cycle
- RD1  in  WIDTH  operand A
- RD2  in  WIDTH  register operand B
- Imm  in  IMM_W  instruction immediate field
- ImmSrc  in  1  0 = zero-extend Imm[11:0]; 1 = sign-extend Imm[IMM_W-1:0]
- ALUSrc  in  2  0 = RD2; 1 = ExtImm; 2 = ExtImm<<2; 3 = all ones
- ALUControl  in  3  operation code (see package)
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes the result
- ALUResult  out  WIDTH  registered result
- ALUFlags  out  4  registered flags {N,Z,C,V} in bits [3:0]
- busy  out  1  high while a MUL is iterating

Behaviour:
- Reset state: state = IDLE; out_valid = 0; ALUResult = 0; ALUFlags = 0; busy = 0; in_ready = 0 while reset is high.
- Reset during a MUL aborts it. No result is produced.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept occurs when in_valid && in_ready. All inputs are sampled at the accept edge only.
- Opcodes: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MUL. Opcodes 11x pass A through.
- ADD: C = carry out; V = signed overflow.
- SUB: computed as A + ~B + 1. C = 1 means no borrow; V = signed overflow.
- Logic ops, MUL and pass-through: C = 0, V = 0.
- All ops: N = result[WIDTH-1]; Z = (result == 0).
- MUL result: low WIDTH bits of the unsigned product A*SrcB.
- Non-MUL ops: result and flags are loaded at the accept edge, so out_valid is high in the next cycle (latency 1). Stays in IDLE.
- MUL, accept edge: go to BUSY. Load mcand = A, mplier = SrcB, acc = 0, cnt = WIDTH.
- MUL, each BUSY edge: if mplier[0], acc += mcand. Then mcand <<= 1, mplier >>= 1, cnt -= 1.
- MUL completion: on the BUSY edge where cnt reaches 0, write the final acc to ALUResult, set out_valid, return to IDLE. Total latency = WIDTH+1 edges after accept.
- busy = (state==BUSY). in_ready = 0 throughout BUSY.
- Output register holds its value while out_valid && !out_ready.
- out_valid falls after an out_ready edge unless a new op is accepted on that same edge.
- Consume and accept on the same edge: a non-MUL op replaces the output with no bubble. A MUL op drops out_valid until it completes.
- The output register is always empty when a MUL completes, so it cannot be overwritten.
- Counter and shift registers wrap only within WIDTH. Product bits above WIDTH are discarded.

Optional Feature:
- Macro: EXEC_MUL_EARLY_TERM_EN.
- Defined: MUL also completes on the BUSY edge where the shifted mplier becomes 0. The minimum is 1 BUSY edge, so SrcB=0 gives latency 2 and SrcB=7 gives latency 4. The result is identical.
- Undefined: MUL always takes WIDTH BUSY edges.

Decomposition:
- Package exec_pkg holds:
  - opcode localparams OP_ADD..OP_MUL;
  - SRCB_RD2 / SRCB_IMM / SRCB_IMM_AL / SRCB_ONES;
  - flag indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - state encoding IDLE/BUSY.
- One sub-module, exec_iter_mul: shift-add datapath and counter with start/done, parametrised by WIDTH and CNT_W.
- Immediate extension, SrcB mux and single-cycle ALU stay inline.

Test Plan:
1. ADD, RD1=0x7FFFFFFF, ALUSrc=0, RD2=1 -> ALUResult=0x80000000, ALUFlags=4'b1001, out_valid one cycle after accept.
2. SUB, RD1=5, ALUSrc=1, ImmSrc=0, Imm=0x000005 -> ALUResult=0, ALUFlags=4'b0110.
3. ADD, RD1=8, ALUSrc=2, ImmSrc=1, Imm=0xFFFFFF -> SrcB=0xFFFFFFFC, ALUResult=4, ALUFlags=4'b0010.
4. MUL, RD1=6, RD2=7 -> ALUResult=42, out_valid 33 edges after accept (4 with EXEC_MUL_EARLY_TERM_EN); busy=1 and in_ready=0 until completion.
5. Backpressure: out_ready=0 holding an AND result with a second op pending -> result stable, in_ready=0; raise out_ready -> consume and accept on the same edge, new result the next cycle.
6. Reset asserted on BUSY cycle 10 of a MUL -> next cycle out_valid=0, busy=0, outputs 0; first op after reset returns a correct, non-stale result.
